// File: rtl/pc_unit.sv
// ---------------------------------------------------------------------------
// pc_unit -- program-counter unit for the instruction fetch stage.
//
// Holds the fetch PC and picks the next PC from, highest priority first:
// reset, trap (TRAP_VECTOR), branch/jump redirect, stall (hold) and
// sequential increment. A redirect to a misaligned target is sent to
// TRAP_VECTOR instead, and a one-cycle misaligned pulse is raised.
// A small BOOT/RUN/HALTED state machine gates fetch validity and halting.
//
// Optional feature macro: RVC_EN
//   defined   : increment is 2 for compressed instructions and 4 otherwise;
//               a target is misaligned when bit 0 is set.
//   undefined : increment is always 4 and inst_compressed is ignored;
//               a target is misaligned when bits [1:0] are non-zero.
//
// Ports
//   clk              in   1     rising-edge clock
//   reset            in   1     synchronous, active-low reset
//   stall            in   1     hold pc_out this cycle
//   redirect_valid   in   1     take redirect_target
//   redirect_target  in   XLEN  redirect destination
//   trap_valid       in   1     jump to TRAP_VECTOR
//   halt_req         in   1     request to stop fetching
//   resume           in   1     leave HALTED state
//   inst_compressed  in   1     current instruction is 16-bit (RVC_EN only)
//   pc_out           out  XLEN  registered fetch PC (IMEM address)
//   pc_next          out  XLEN  value pc_out takes at the next edge
//   pc_valid         out  1     pc_out is a valid fetch address
//   misaligned       out  1     one-cycle pulse: last redirect was misaligned
//   halted           out  1     unit is in HALTED state
//   state_dbg        out  2     current FSM state (BOOT=0, RUN=1, HALTED=2)
//
// Handshake: there is no ready back-pressure. Every request input is a
// level sampled at each rising edge; its effect is visible on the
// registered outputs right after that edge.
// ---------------------------------------------------------------------------
module pc_unit #(
    parameter int              XLEN         = 32,
    parameter logic [XLEN-1:0] RESET_VECTOR = XLEN'(32'h0000_0000),
    parameter logic [XLEN-1:0] TRAP_VECTOR  = XLEN'(32'h0000_0100)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            stall,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_target,
    input  logic            trap_valid,
    input  logic            halt_req,
    input  logic            resume,
    input  logic            inst_compressed,
    output logic [XLEN-1:0] pc_out,
    output logic [XLEN-1:0] pc_next,
    output logic            pc_valid,
    output logic            misaligned,
    output logic            halted,
    output logic [1:0]      state_dbg
);

    typedef enum logic [1:0] {
        BOOT   = 2'd0,
        RUN    = 2'd1,
        HALTED = 2'd2
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic [XLEN-1:0] pc_q;
    logic            misaligned_q;
    logic            misaligned_nxt;
    logic [XLEN-1:0] increment;
    logic            target_bad;

`ifdef RVC_EN
    assign increment  = inst_compressed ? XLEN'(2) : XLEN'(4);
    assign target_bad = redirect_target[0];
`else
    assign increment  = XLEN'(4);
    assign target_bad = |redirect_target[1:0];
    // inst_compressed has no meaning without compressed-instruction support.
    logic unused_inst_compressed;
    assign unused_inst_compressed = inst_compressed;
`endif

    // Next-state logic. A stalled halt request waits until the stall clears,
    // and resume wins over a simultaneous halt_req while HALTED.
    always_comb begin
        state_nxt = state;
        case (state)
            BOOT:    state_nxt = RUN;
            RUN:     if (halt_req && !stall) state_nxt = HALTED;
            HALTED:  if (resume) state_nxt = RUN;
            default: state_nxt = BOOT;
        endcase
    end

    // Next-PC selection. The PC only advances sequentially in RUN, and not
    // on the edge that enters HALTED, so the halted PC is the one that was
    // showing when the halt was accepted.
    always_comb begin
        pc_nxt_sel:
        begin
            pc_next        = pc_q;
            misaligned_nxt = 1'b0;
            if (!reset) begin
                pc_next = RESET_VECTOR;
            end else if (trap_valid) begin
                pc_next = TRAP_VECTOR;
            end else if (redirect_valid) begin
                if (target_bad) begin
                    pc_next        = TRAP_VECTOR;
                    misaligned_nxt = 1'b1;
                end else begin
                    pc_next = redirect_target;
                end
            end else if (stall) begin
                pc_next = pc_q;
            end else if (state == RUN && !halt_req) begin
                pc_next = pc_q + increment;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state        <= BOOT;
            pc_q         <= RESET_VECTOR;
            misaligned_q <= 1'b0;
        end else begin
            state        <= state_nxt;
            pc_q         <= pc_next;
            misaligned_q <= misaligned_nxt;
        end
    end

    assign pc_out     = pc_q;
    assign misaligned = misaligned_q;
    assign pc_valid   = (state == RUN);
    assign halted     = (state == HALTED);
    assign state_dbg  = state;

endmodule

// File: tb/tb_pc_unit.sv
// ---------------------------------------------------------------------------
// tb_pc_unit -- directed self-checking bench for pc_unit (default parameters).
// Inputs change 1 time unit after a rising edge; outputs are sampled at the
// same point, so the values seen reflect the edge that just happened.
// Build with +define+RVC_EN to check the compressed-instruction variant.
// ---------------------------------------------------------------------------
module tb_pc_unit;

    logic        clk;
    logic        reset;
    logic        stall;
    logic        redirect_valid;
    logic [31:0] redirect_target;
    logic        trap_valid;
    logic        halt_req;
    logic        resume;
    logic        inst_compressed;
    logic [31:0] pc_out;
    logic [31:0] pc_next;
    logic        pc_valid;
    logic        misaligned;
    logic        halted;
    logic [1:0]  state_dbg;

    int tests_run    = 0;
    int tests_failed = 0;

`ifdef RVC_EN
    localparam logic [31:0] MIS_PC    = 32'h0000_0202;
    localparam logic        MIS_PULSE = 1'b0;
`else
    localparam logic [31:0] MIS_PC    = 32'h0000_0100;
    localparam logic        MIS_PULSE = 1'b1;
`endif

    pc_unit dut (
        .clk             (clk),
        .reset           (reset),
        .stall           (stall),
        .redirect_valid  (redirect_valid),
        .redirect_target (redirect_target),
        .trap_valid      (trap_valid),
        .halt_req        (halt_req),
        .resume          (resume),
        .inst_compressed (inst_compressed),
        .pc_out          (pc_out),
        .pc_next         (pc_next),
        .pc_valid        (pc_valid),
        .misaligned      (misaligned),
        .halted          (halted),
        .state_dbg       (state_dbg)
    );

    // clock / reset block
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // driver tasks
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        stall           = 1'b0;
        redirect_valid  = 1'b0;
        redirect_target = 32'h0;
        trap_valid      = 1'b0;
        halt_req        = 1'b0;
        resume          = 1'b0;
        inst_compressed = 1'b0;
    endtask

    // Reset, release and pass the BOOT edge: leaves pc_out=0 in RUN.
    task automatic do_reset();
        idle_inputs();
        reset = 1'b0;
        step();
        reset = 1'b1;
        step();
    endtask

    task automatic test_reset();
        idle_inputs();
        reset = 1'b0;
        step();
        step();
        tests_run++;
        if (pc_out !== 32'h0 || pc_valid !== 1'b0 || halted !== 1'b0 || misaligned !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_state: pc_out=%h valid=%b halted=%b mis=%b, expected 0/0/0/0",
                     pc_out, pc_valid, halted, misaligned);
        end
        reset = 1'b1;
        tests_run++;
        if (state_dbg !== 2'd0 || pc_next !== 32'h0) begin
            tests_failed++;
            $display("FAIL boot_state: state=%0d pc_next=%h, expected 0 / 00000000", state_dbg, pc_next);
        end
        step();
        tests_run++;
        if (pc_out !== 32'h0 || pc_valid !== 1'b1) begin
            tests_failed++;
            $display("FAIL boot_exit: pc_out=%h valid=%b, expected 00000000/1", pc_out, pc_valid);
        end
        tests_run++;
        if (pc_next !== 32'h4) begin
            tests_failed++;
            $display("FAIL pc_next_seq: pc_next=%h, expected 00000004", pc_next);
        end
        for (int i = 1; i <= 3; i++) begin
            step();
            tests_run++;
            if (pc_out !== 32'(i * 4) || pc_valid !== 1'b1) begin
                tests_failed++;
                $display("FAIL seq_step%0d: pc_out=%h valid=%b, expected %h/1", i, pc_out, pc_valid, 32'(i * 4));
            end
        end
    endtask

    task automatic test_stall();
        do_reset();
        step();
        step();
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            tests_run++;
            if (pc_out !== 32'h8) begin
                tests_failed++;
                $display("FAIL stall_hold%0d: pc_out=%h, expected 00000008", i, pc_out);
            end
        end
        stall = 1'b0;
        step();
        tests_run++;
        if (pc_out !== 32'hC) begin
            tests_failed++;
            $display("FAIL stall_release1: pc_out=%h, expected 0000000c", pc_out);
        end
        step();
        tests_run++;
        if (pc_out !== 32'h10) begin
            tests_failed++;
            $display("FAIL stall_release2: pc_out=%h, expected 00000010", pc_out);
        end
    endtask

    task automatic test_redirect();
        stall           = 1'b1;
        redirect_valid  = 1'b1;
        redirect_target = 32'h0000_0200;
        #1;
        tests_run++;
        if (pc_next !== 32'h200) begin
            tests_failed++;
            $display("FAIL redirect_pc_next: pc_next=%h, expected 00000200", pc_next);
        end
        step();
        idle_inputs();
        tests_run++;
        if (pc_out !== 32'h200 || misaligned !== 1'b0) begin
            tests_failed++;
            $display("FAIL redirect_stall: pc_out=%h mis=%b, expected 00000200/0", pc_out, misaligned);
        end
    endtask

    task automatic test_misaligned();
        redirect_valid  = 1'b1;
        redirect_target = 32'h0000_0202;
        step();
        idle_inputs();
        tests_run++;
        if (pc_out !== MIS_PC || misaligned !== MIS_PULSE) begin
            tests_failed++;
            $display("FAIL misaligned_target: pc_out=%h mis=%b, expected %h/%b",
                     pc_out, misaligned, MIS_PC, MIS_PULSE);
        end
        step();
        tests_run++;
        if (pc_out !== MIS_PC + 32'h4 || misaligned !== 1'b0) begin
            tests_failed++;
            $display("FAIL misaligned_pulse_end: pc_out=%h mis=%b, expected %h/0",
                     pc_out, misaligned, MIS_PC + 32'h4);
        end
    endtask

    task automatic test_halt();
        redirect_valid  = 1'b1;
        redirect_target = 32'h0000_0010;
        step();
        idle_inputs();
        halt_req = 1'b1;
        step();
        tests_run++;
        if (halted !== 1'b1 || pc_valid !== 1'b0 || pc_out !== 32'h10) begin
            tests_failed++;
            $display("FAIL halt_enter: halted=%b valid=%b pc_out=%h, expected 1/0/00000010",
                     halted, pc_valid, pc_out);
        end
        step();
        tests_run++;
        if (halted !== 1'b1 || pc_out !== 32'h10) begin
            tests_failed++;
            $display("FAIL halt_hold: halted=%b pc_out=%h, expected 1/00000010", halted, pc_out);
        end
        resume = 1'b1;
        step();
        tests_run++;
        if (halted !== 1'b0 || pc_valid !== 1'b1 || pc_out !== 32'h10 || state_dbg !== 2'd1) begin
            tests_failed++;
            $display("FAIL resume_priority: halted=%b valid=%b pc_out=%h state=%0d, expected 0/1/00000010/1",
                     halted, pc_valid, pc_out, state_dbg);
        end
        idle_inputs();
        step();
        tests_run++;
        if (pc_out !== 32'h14) begin
            tests_failed++;
            $display("FAIL resume_continue: pc_out=%h, expected 00000014", pc_out);
        end
    endtask

    task automatic test_trap();
        trap_valid      = 1'b1;
        redirect_valid  = 1'b1;
        redirect_target = 32'h0000_0200;
        step();
        idle_inputs();
        tests_run++;
        if (pc_out !== 32'h100 || misaligned !== 1'b0) begin
            tests_failed++;
            $display("FAIL trap_priority: pc_out=%h mis=%b, expected 00000100/0", pc_out, misaligned);
        end
        halt_req = 1'b1;
        step();
        idle_inputs();
        redirect_valid  = 1'b1;
        redirect_target = 32'h0000_0300;
        step();
        idle_inputs();
        tests_run++;
        if (pc_out !== 32'h300 || halted !== 1'b1) begin
            tests_failed++;
            $display("FAIL redirect_in_halt: pc_out=%h halted=%b, expected 00000300/1", pc_out, halted);
        end
        resume = 1'b1;
        step();
        idle_inputs();
        step();
        tests_run++;
        if (pc_out !== 32'h304 || pc_valid !== 1'b1) begin
            tests_failed++;
            $display("FAIL resume_after_redirect: pc_out=%h valid=%b, expected 00000304/1", pc_out, pc_valid);
        end
    endtask

    task automatic test_wrap();
        redirect_valid  = 1'b1;
        redirect_target = 32'hFFFF_FFFC;
        step();
        idle_inputs();
        step();
        tests_run++;
        if (pc_out !== 32'h0 || misaligned !== 1'b0 || pc_valid !== 1'b1) begin
            tests_failed++;
            $display("FAIL wrap: pc_out=%h mis=%b valid=%b, expected 00000000/0/1", pc_out, misaligned, pc_valid);
        end
    endtask

    task automatic test_reset_mid_run();
        step();
        step();
        reset           = 1'b0;
        redirect_valid  = 1'b1;
        redirect_target = 32'h0000_0400;
        step();
        tests_run++;
        if (pc_out !== 32'h0 || pc_valid !== 1'b0 || halted !== 1'b0 || misaligned !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_mid_run: pc_out=%h valid=%b halted=%b mis=%b, expected 0/0/0/0",
                     pc_out, pc_valid, halted, misaligned);
        end
        idle_inputs();
        reset = 1'b1;
    endtask

    initial begin
        reset = 1'b0;
        idle_inputs();
        test_reset();
        test_stall();
        test_redirect();
        test_misaligned();
        test_halt();
        test_trap();
        test_wrap();
        test_reset_mid_run();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
